// File: rtl/cfs_apb_chk_pkg.sv
// Shared types for the APB protocol checker: bus-phase FSM states, error codes, priority encoder.
package cfs_apb_chk_pkg;

    localparam int NUM_ERR = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [3:0] {
        ERR_NONE           = 4'd0,
        ERR_SETUP_PENABLE  = 4'd1,
        ERR_ACCESS_PENABLE = 4'd2,
        ERR_PSEL_CHANGE    = 4'd3,
        ERR_CTRL_CHANGE    = 4'd4,
        ERR_WDATA_CHANGE   = 4'd5,
        ERR_PSEL_MULTI     = 4'd6,
        ERR_TIMEOUT        = 4'd7,
        ERR_READ_PSTRB     = 4'd8
    } err_code_e;

    // Bit i of the vector carries error code i+1; the lowest code wins.
    function automatic err_code_e prio_code(input logic [NUM_ERR-1:0] vec);
        prio_code = ERR_NONE;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (vec[i]) prio_code = err_code_e'(4'(i + 1));
        end
    endfunction

endpackage

// File: rtl/cfs_apb_chk_err_log.sv
// Error log: registered error pulse/code, sticky bits, saturating cycle count, first-error address.
// A new error in the same cycle as clr_errors is logged on top of the clear.
module cfs_apb_chk_err_log
    import cfs_apb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  clr_errors,
    input  logic [NUM_ERR-1:0]    err_vec,
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic                  err_valid,
    output logic [3:0]            err_code,
    output logic [NUM_ERR-1:0]    err_sticky,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    logic                  any_err;
    logic                  valid_q;
    err_code_e             code_q,   code_d;
    logic [NUM_ERR-1:0]    sticky_q, sticky_d;
    logic [15:0]           count_q,  count_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;

    always_comb begin
        any_err  = |err_vec;
        code_d   = prio_code(err_vec);
        sticky_d = (clr_errors ? '0 : sticky_q) | err_vec;
        count_d  = clr_errors ? 16'd0 : count_q;
        if (any_err && (count_d != 16'hFFFF)) begin
            count_d = count_d + 16'd1;
        end
        addr_d = clr_errors ? '0 : addr_q;
        // Only the first error since the log was last empty records an address.
        if (any_err && (clr_errors || (sticky_q == '0))) begin
            addr_d = paddr;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            valid_q  <= 1'b0;
            code_q   <= ERR_NONE;
            sticky_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
        end else begin
            valid_q  <= any_err;
            code_q   <= code_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    assign err_valid  = valid_q;
    assign err_code   = code_q;
    assign err_sticky = sticky_q;
    assign err_count  = count_q;
    assign err_addr   = addr_q;

endmodule

// File: rtl/cfs_apb_protocol_checker.sv
// Passive APB protocol checker: follows IDLE/SETUP/ACCESS, flags protocol violations, counts transfers.
// All outputs are registered one cycle after the sampled edge; the checker never drives the bus.
module cfs_apb_protocol_checker
    import cfs_apb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    has_checks,
    input  logic                    clr_errors,
    input  logic [NUM_SLAVES-1:0]   psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr,
    output logic                    err_valid,
    output logic [3:0]              err_code,
    output logic [NUM_ERR-1:0]      err_sticky,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    xfer_done,
    output logic [31:0]             xfer_count
);

    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    apb_state_e            state_q, state_d;
    logic [NUM_SLAVES-1:0] psel_lat_q,  psel_lat_d;
    logic [ADDR_WIDTH-1:0] paddr_lat_q, paddr_lat_d;
    logic                  pwrite_lat_q, pwrite_lat_d;
    logic [DATA_WIDTH-1:0] pwdata_lat_q, pwdata_lat_d;
    logic [STRB_W-1:0]     pstrb_lat_q, pstrb_lat_d;
    logic [7:0]            wait_q, wait_d;
    logic                  done_q, done_d;
    logic [31:0]           xcnt_q, xcnt_d;

    logic                  psel_any;
    logic                  psel_multi;
    logic [NUM_SLAVES-1:0] psel_m1;
    logic [NUM_ERR-1:0]    err_raw;
    logic [NUM_ERR-1:0]    err_vec;
    logic                  unused_obs;

    // prdata and pslverr are legal in any combination; only observed.
    assign unused_obs = ^{prdata, pslverr};

    // state_d is the bus phase of the cycle being sampled now; state_q holds the previous one.
    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE:   state_d = psel_any ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (done_q) state_d = psel_any ? ST_SETUP : ST_IDLE;
                else        state_d = ST_ACCESS;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        psel_any     = |psel;
        psel_m1      = psel - NUM_SLAVES'(1);
        psel_multi   = psel_any && ((psel & psel_m1) != '0);
        err_raw      = '0;
        psel_lat_d   = psel_lat_q;
        paddr_lat_d  = paddr_lat_q;
        pwrite_lat_d = pwrite_lat_q;
        pwdata_lat_d = pwdata_lat_q;
        pstrb_lat_d  = pstrb_lat_q;
        wait_d       = wait_q;
        done_d       = 1'b0;
        xcnt_d       = xcnt_q;

        if (state_d == ST_SETUP) begin
            psel_lat_d   = psel;
            paddr_lat_d  = paddr;
            pwrite_lat_d = pwrite;
            pwdata_lat_d = pwdata;
            pstrb_lat_d  = pstrb;
            wait_d       = 8'd0;
            err_raw[0]   = penable;
            err_raw[7]   = !pwrite && (pstrb != '0);
        end

        if (state_d == ST_ACCESS) begin
            err_raw[1] = !penable;
            err_raw[2] = (psel != psel_lat_q);
            err_raw[3] = (paddr != paddr_lat_q) || (pwrite != pwrite_lat_q) ||
                         (pstrb != pstrb_lat_q);
            err_raw[4] = pwrite && (pwdata != pwdata_lat_q);
            if (pready) begin
                done_d = 1'b1;
                xcnt_d = xcnt_q + 32'd1;
            end else if (wait_q < TMO) begin
                // Counter parks at TIMEOUT so the timeout fires exactly once.
                wait_d     = wait_q + 8'd1;
                err_raw[6] = (wait_q == (TMO - 8'd1));
            end
        end

        err_raw[5] = psel_multi;
        err_vec    = has_checks ? err_raw : '0;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            psel_lat_q   <= '0;
            paddr_lat_q  <= '0;
            pwrite_lat_q <= 1'b0;
            pwdata_lat_q <= '0;
            pstrb_lat_q  <= '0;
            wait_q       <= 8'd0;
            done_q       <= 1'b0;
            xcnt_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            psel_lat_q   <= psel_lat_d;
            paddr_lat_q  <= paddr_lat_d;
            pwrite_lat_q <= pwrite_lat_d;
            pwdata_lat_q <= pwdata_lat_d;
            pstrb_lat_q  <= pstrb_lat_d;
            wait_q       <= wait_d;
            done_q       <= done_d;
            xcnt_q       <= xcnt_d;
        end
    end

    cfs_apb_chk_err_log #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_err_log (
        .pclk       (pclk),
        .preset     (preset),
        .clr_errors (clr_errors),
        .err_vec    (err_vec),
        .paddr      (paddr),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .err_addr   (err_addr)
    );

    assign xfer_done  = done_q;
    assign xfer_count = xcnt_q;

endmodule

// File: tb/tb_cfs_apb_protocol_checker.sv
// Directed bench for cfs_apb_protocol_checker: per-cycle expectations queued at drive time,
// popped and compared one cycle later; log registers checked at the end of each scenario.
module tb_cfs_apb_protocol_checker;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int TO = 16;

    logic            pclk       = 1'b0;
    logic            preset     = 1'b1;
    logic            has_checks = 1'b1;
    logic            clr_errors = 1'b0;
    logic [NS-1:0]   psel       = '0;
    logic            penable    = 1'b0;
    logic            pwrite     = 1'b0;
    logic [AW-1:0]   paddr      = '0;
    logic [DW-1:0]   pwdata     = '0;
    logic [DW/8-1:0] pstrb      = '0;
    logic            pready     = 1'b0;
    logic [DW-1:0]   prdata     = '0;
    logic            pslverr    = 1'b0;

    logic            err_valid;
    logic [3:0]      err_code;
    logic [7:0]      err_sticky;
    logic [15:0]     err_count;
    logic [AW-1:0]   err_addr;
    logic            xfer_done;
    logic [31:0]     xfer_count;

    typedef struct packed {
        logic       vld;
        logic [3:0] code;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   n_fail    = 0;
    int   exp_xfers = 0;

    always #5 pclk = ~pclk;

    cfs_apb_protocol_checker #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SLAVES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .has_checks (has_checks),
        .clr_errors (clr_errors),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .err_addr   (err_addr),
        .xfer_done  (xfer_done),
        .xfer_count (xfer_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle, queue what the registered outputs must show after this edge.
    task automatic cyc(input logic [NS-1:0] s, input logic en, input logic wr,
                       input logic [AW-1:0] a, input logic [3:0] st, input logic rdy,
                       input logic ev, input logic [3:0] ec, input logic ed);
        exp_t e;
        psel    = s;
        penable = en;
        pwrite  = wr;
        paddr   = a;
        pstrb   = st;
        pready  = rdy;
        sb.push_back('{vld: ev, code: ec, done: ed});
        if (ed) exp_xfers++;
        @(posedge pclk);
        #1;
        e = sb.pop_front();
        check("err_valid", 32'(err_valid), 32'(e.vld));
        check("err_code",  32'(err_code),  32'(e.code));
        check("xfer_done", 32'(xfer_done), 32'(e.done));
    endtask

    task automatic check_log(input string tag, input logic [7:0] st, input logic [15:0] cnt,
                             input logic [AW-1:0] addr);
        check({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
        check({tag, ".err_count"},  32'(err_count),  32'(cnt));
        check({tag, ".err_addr"},   32'(err_addr),   32'(addr));
        check({tag, ".xfer_count"}, xfer_count,      32'(exp_xfers));
    endtask

    task automatic clear_log();
        clr_errors = 1'b1;
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        clr_errors = 1'b0;
        check_log("clear", 8'h00, 16'd0, 16'h0000);
    endtask

    initial begin
        pwdata = 32'hA5A5_0001;
        repeat (2) @(posedge pclk);
        #1;
        check("reset.err_valid", 32'(err_valid), 32'd0);
        check("reset.err_code",  32'(err_code),  32'd0);
        check("reset.xfer_done", 32'(xfer_done), 32'd0);
        check_log("reset", 8'h00, 16'd0, 16'h0000);
        preset = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Clean zero-wait write
        cyc(2'b01, 1'b0, 1'b1, 16'h0010, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 16'h0010, 4'hF, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_log("clean", 8'h00, 16'd0, 16'h0000);

        // penable high during setup
        cyc(2'b01, 1'b1, 1'b1, 16'h0020, 4'hF, 1'b0, 1'b1, 4'd1, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 16'h0020, 4'hF, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_log("setup_pen", 8'h01, 16'd1, 16'h0020);
        clear_log();

        // Address glitch on the first access cycle, then a stall past TIMEOUT
        cyc(2'b01, 1'b0, 1'b1, 16'h0010, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 16'h0014, 4'hF, 1'b0, 1'b1, 4'd4, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            cyc(2'b01, 1'b1, 1'b1, 16'h0010, 4'hF, 1'b0,
                (k == TO), (k == TO) ? 4'd7 : 4'd0, 1'b0);
        end
        cyc(2'b01, 1'b1, 1'b1, 16'h0010, 4'hF, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_log("timeout", 8'h48, 16'd2, 16'h0014);
        clear_log();

        // Two slaves selected at once, then the same with checks disabled
        cyc(2'b11, 1'b0, 1'b1, 16'h0030, 4'hF, 1'b0, 1'b1, 4'd6, 1'b0);
        cyc(2'b11, 1'b1, 1'b1, 16'h0030, 4'hF, 1'b1, 1'b1, 4'd6, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_log("multi_sel", 8'h20, 16'd2, 16'h0030);
        clear_log();
        has_checks = 1'b0;
        cyc(2'b11, 1'b1, 1'b1, 16'h0030, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b11, 1'b1, 1'b1, 16'h0030, 4'hF, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        has_checks = 1'b1;
        check_log("no_checks", 8'h00, 16'd0, 16'h0000);

        // Clear coincident with a code-2 error: the new error survives the clear
        cyc(2'b01, 1'b1, 1'b1, 16'h0040, 4'hF, 1'b0, 1'b1, 4'd1, 1'b0);
        clr_errors = 1'b1;
        cyc(2'b01, 1'b0, 1'b1, 16'h0040, 4'hF, 1'b0, 1'b1, 4'd2, 1'b0);
        clr_errors = 1'b0;
        check_log("clr_set", 8'h02, 16'd1, 16'h0040);
        cyc(2'b01, 1'b1, 1'b1, 16'h0040, 4'hF, 1'b1, 1'b0, 4'd0, 1'b1);

        // Reset in the middle of an access phase
        cyc(2'b01, 1'b0, 1'b1, 16'h0050, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 16'h0050, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        preset = 1'b1;
        #1;
        exp_xfers = 0;
        check("async_rst.err_valid", 32'(err_valid), 32'd0);
        check("async_rst.xfer_done", 32'(xfer_done), 32'd0);
        check_log("async_rst", 8'h00, 16'd0, 16'h0000);
        @(posedge pclk);
        #1;
        preset = 1'b0;
        cyc(2'b01, 1'b0, 1'b1, 16'h0060, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        pslverr = 1'b1;
        cyc(2'b01, 1'b1, 1'b1, 16'h0060, 4'hF, 1'b1, 1'b0, 4'd0, 1'b1);
        pslverr = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_log("post_rst", 8'h00, 16'd0, 16'h0000);

        // Read with strobes set in setup, then a write whose data moves in access
        cyc(2'b01, 1'b0, 1'b0, 16'h0070, 4'h1, 1'b0, 1'b1, 4'd8, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 16'h0070, 4'h1, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(2'b01, 1'b0, 1'b1, 16'h0080, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);
        pwdata = 32'h1234_5678;
        cyc(2'b01, 1'b1, 1'b1, 16'h0080, 4'hF, 1'b1, 1'b1, 4'd5, 1'b1);
        cyc(2'b00, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_log("strb_wdata", 8'h90, 16'd2, 16'h0070);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cfs_apb_protocol_checker.md
CFS_APB_PROTOCOL_CHECKER -- requirements
Module: cfs_apb_protocol_checker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, pwdata/prdata width; legal values are 8, 16 and 32; pstrb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_SLAVES, default 1, psel vector width (1..16).
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum number of pready=0 cycles in one access phase (2..255).
REQ-005 Ports SHALL be as follows. The block has one clock. Reset is asynchronous and active-high:
- pclk  in  1  clock
- preset  in  1  async active-high reset
- has_checks  in  1  check enable
- clr_errors  in  1  clear error log
- psel  in  NUM_SLAVES  slave selects
- penable  in  1
- pwrite  in  1
- paddr  in  ADDR_WIDTH
- pwdata  in  DATA_WIDTH
- pstrb  in  DATA_WIDTH/8
- pready  in  1
- prdata  in  DATA_WIDTH  (observed only)
- pslverr  in  1
- err_valid  out  1  one-cycle pulse, an error was detected this cycle
- err_code  out  4  highest-priority error this cycle
- err_sticky  out  8  one bit per error code 1..8
- err_count  out  16  saturating error-cycle count
- err_addr  out  ADDR_WIDTH  paddr captured at the first logged error
- xfer_done  out  1  pulse on each completed transfer
- xfer_count  out  32  completed transfers, wraps

Function
REQ-006 SHALL track the bus with FSM IDLE/SETUP/ACCESS, evaluated on posedge pclk.
REQ-007 IDLE: psel!=0 -> SETUP, latch psel, paddr, pwrite, pwdata, pstrb.
REQ-008 SETUP: the next cycle SHALL be ACCESS unconditionally.
REQ-009 ACCESS with pready=1 -> xfer_done=1 next cycle; then psel!=0 -> SETUP (relatch), else IDLE.
REQ-010 Error codes (lower code = higher priority):
- 1: penable=1 in a setup cycle.
- 2: penable=0 in an access cycle.
- 3: psel differs from the latched value in access.
- 4: paddr/pwrite/pstrb differ from latched in access.
- 5: pwrite=1 and pwdata differs from latched in access.
- 6: psel not one-hot while nonzero.
- 7: TIMEOUT.
- 8: pwrite=0 with pstrb!=0 in setup.
REQ-011 Wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle with pready=0; error 7 SHALL fire once when the count reaches TIMEOUT; the FSM stays in ACCESS.
REQ-012 Multiple simultaneous errors: set every corresponding err_sticky bit; err_code reports the lowest code; err_count increments by 1 per cycle, saturating at 16'hFFFF.
REQ-013 err_valid, err_code, xfer_done SHALL be registered, with 1-cycle latency from the sampled edge; err_code=0 when err_valid=0.
REQ-014 err_addr SHALL capture only when err_sticky is all-zero before the error.
REQ-015 clr_errors=1 SHALL clear err_sticky, err_count and err_addr; if an error occurs in the same cycle, the new error is logged (count=1), so set wins over clear.
REQ-016 has_checks=0 SHALL suppress all error reporting; FSM, xfer_done and xfer_count keep operating.
REQ-017 pslverr SHALL NOT be an error; the transfer completes normally.

Reset
REQ-018 preset=1 SHALL asynchronously force FSM=IDLE, wait counter=0, and all outputs=0, including mid-transfer; the first cycle after release is evaluated from IDLE.

Structure
REQ-019 Package cfs_apb_chk_pkg SHALL hold the FSM state enum, the error-code enum (4-bit), and NUM_ERR=8.
REQ-020 Sub-module cfs_apb_chk_err_log SHALL implement err_sticky, err_count, err_addr, clear and priority encode.

Verification
REQ-021 Write to 16'h0010, 0 waits -> xfer_done 1 cycle after access, xfer_count=1, err_sticky=0.
REQ-022 penable=1 in setup -> err_valid, err_code=1, err_sticky=8'h01, err_addr=setup paddr.
REQ-023 paddr changes 16'h0010->16'h0014 in access and pready held 0 for 20 cycles (TIMEOUT=16) -> codes 4 then 7, err_sticky=8'h48, err_count=2.
REQ-024 psel=2'b11 (NUM_SLAVES=2) -> err_code=6; repeat with has_checks=0 -> no err_valid.
REQ-025 clr_errors coincident with a code-2 error -> err_sticky=8'h02, err_count=1.
REQ-026 preset asserted in ACCESS -> outputs 0 immediately, next psel starts a clean SETUP with no error.
